pc_fetch_sequencer: RTL
=======================

# pc_fetch_sequencer

Sequences the fetch stage of the MIPS core: owns the program-counter register, drives the existing `pcplus4` incrementer and `pc_multiplexer` to pick the next PC, and runs a request/acknowledge handshake with instruction memory. Delivers one instruction at a time to decode, holds it under stall, and applies branch/jump redirects with squash of in-flight fetches.

## Interface
- `WIDTH`, 32, PC and instruction width in bits
- `RESET_PC`, 32'h0000_0000, PC loaded on reset (low 2 bits must be 0)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request; held until `imem_ack`
- `imem_addr`  out  WIDTH  fetch address; stable while `imem_req`=1
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; may arrive in the cycle `imem_req` rises
- `imem_rdata`  in  WIDTH  fetched instruction word
- `stall`  in  1  decode cannot accept; hold current instruction
- `branch_taken`  in  1  redirect to `branch_target` (older instruction, highest priority)
- `branch_target`  in  WIDTH  branch destination
- `jump`  in  1  redirect to `jump_target`
- `jump_target`  in  WIDTH  jump destination
- `instr_valid`  out  1  `instr` / `instr_pc` valid for decode
- `instr`  out  WIDTH  instruction word
- `instr_pc`  out  WIDTH  address of `instr`

## Operation
- States: FETCH (`imem_req`=1, `imem_addr`=pc), DELIVER (`instr_valid`=1). Reset state FETCH.
- Redirect target = `branch_target` if `branch_taken`, else `jump_target` if `jump`; both high → branch wins. Target low 2 bits forced to 0.
- FETCH, `imem_ack`=1, no redirect this cycle, no pending redirect: `instr`←`imem_rdata`, `instr_pc`←pc → DELIVER.
- FETCH, redirect, `imem_ack`=0: pc must not change (address stability); target stored in pending register, pending flag set. A later redirect before ack overwrites the pending target (same priority rule).
- FETCH, `imem_ack`=1 with redirect this cycle or pending set: returned word discarded; pc←newest target (this-cycle redirect beats pending); pending cleared; stay FETCH.
- DELIVER, redirect: `instr_valid` drops next cycle, pc←target, → FETCH, regardless of `stall`.
- DELIVER, no redirect, `stall`=0: pc←pc+4 (via `pcplus4`), → FETCH.
- DELIVER, no redirect, `stall`=1: stay; `instr`, `instr_pc` held unchanged.
- `imem_ack` outside FETCH is ignored.
- pc+4 wraps modulo 2^WIDTH (0xFFFF_FFFC → 0x0000_0000).

## Timing
- While `reset`=1 (sampled at edge): pc=`RESET_PC`, state FETCH, pending=0; outputs `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0. `imem_req`, `instr_valid` gated low during the reset cycle.
- First cycle after reset deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Zero-wait memory (ack same cycle as req): `instr_valid` one cycle after ack; best-case throughput 1 instruction / 2 cycles.
- Redirect in DELIVER: new `imem_addr` presented the very next cycle.
- Reset mid-handshake: outstanding fetch abandoned, pending cleared; any late ack in reset cycle ignored.
- `imem_req`, `imem_addr`, `instr_valid` are functions of registered state only (no combinational path from `stall`, `branch_taken`, `jump`, `imem_ack`).

## Structure
- Shared package `mips_pkg`: `fetch_state_t` enum {FETCH, DELIVER}, `PC_ALIGN_MASK` constant, `RESET_PC` default.
- Reuse existing `pcplus4` for increment and `pc_multiplexer` for sequential/redirect select; no new sub-module.
- Registers: pc, state, pending flag, pending target, instr, instr_pc.

## Test plan
- Reset release, zero-wait memory returning 0x2001_0005 at 0x0 → req at 0x0 in cycle 1, `instr_valid`=1 cycle 2 with `instr_pc`=0x0, then req at 0x4 in cycle 3.
- `stall` high 3 cycles in DELIVER at pc 0x8 → `instr`, `instr_pc`=0x8 held 4 cycles, no req; req 0xC the cycle after `stall` drops.
- Memory with 3-cycle ack latency at 0x10, `jump` to 0x40 in wait cycle 1 → `imem_addr` stays 0x10 until ack, word discarded, next req at 0x40, no `instr_valid` for 0x10.
- `branch_taken` (0x100) and `jump` (0x200) together in DELIVER, `stall`=1 → next req at 0x100, `instr_valid` low.
- pc=0xFFFF_FFFC delivered, `stall`=0 → next req at 0x0; `branch_target`=0x103 → req at 0x100.
- `reset` asserted while awaiting ack at 0x20 → outputs at reset values, first req after release at `RESET_PC`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS core.
package mips_pkg;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DELIVER = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-stage bundle: instruction-memory handshake plus decode/redirect signals.
interface pc_fetch_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             instr_valid;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, stall, branch_taken, branch_target,
               jump, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, stall, branch_taken, branch_target,
               jump, jump_target
    );
endinterface

// File: rtl/pc_multiplexer.sv
// Next-PC select between the sequential address and a redirect target.
module pc_multiplexer #(
    parameter int WIDTH = 32
) (
    input  logic             sel_redirect_i,
    input  logic [WIDTH-1:0] pc_seq_i,
    input  logic [WIDTH-1:0] pc_redirect_i,
    output logic [WIDTH-1:0] pc_next_o
);
    assign pc_next_o = sel_redirect_i ? pc_redirect_i : pc_seq_i;
endmodule

// File: rtl/pcplus4.sv
// Sequential PC incrementer; wraps modulo 2^WIDTH.
module pcplus4 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] pc_plus4_o
);
    assign pc_plus4_o = pc_i + WIDTH'(4);
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: owns the PC, handshakes with instruction memory, delivers
// one instruction at a time to decode and applies branch/jump redirects.
//
// state   | meaning
// FETCH   | imem_req high at pc; waiting for imem_ack
// DELIVER | instr/instr_pc valid to decode; held while stall
module pc_fetch_sequencer
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic       clk,
    input  logic       reset,
    pc_fetch_if.master bus
);
    localparam logic [WIDTH-1:0] ALIGN = {{(WIDTH-2){1'b1}}, PC_ALIGN_MASK[1:0]};

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;

    logic             redirect;
    logic [WIDTH-1:0] redir_tgt;
    logic [WIDTH-1:0] newest_tgt;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_next;

    assign redirect   = bus.branch_taken | bus.jump;
    assign redir_tgt  = (bus.branch_taken ? bus.branch_target : bus.jump_target) & ALIGN;
    // A redirect seen this cycle is younger than anything already pending.
    assign newest_tgt = redirect ? redir_tgt : pend_tgt_q;

    pcplus4 #(.WIDTH(WIDTH)) u_pcplus4 (
        .pc_i       (pc_q),
        .pc_plus4_o (pc_plus4)
    );

    pc_multiplexer #(.WIDTH(WIDTH)) u_pc_mux (
        .sel_redirect_i (redirect || (state_q == FETCH)),
        .pc_seq_i       (pc_plus4),
        .pc_redirect_i  (newest_tgt),
        .pc_next_o      (pc_next)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_ack) begin
                    if (redirect || pend_q) begin
                        pc_d   = pc_next;
                        pend_d = 1'b0;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = DELIVER;
                    end
                end else if (redirect) begin
                    // imem_addr must stay put until the ack, so park the target.
                    pend_d     = 1'b1;
                    pend_tgt_d = redir_tgt;
                end
            end
            DELIVER: begin
                if (redirect || !bus.stall) begin
                    pc_d    = pc_next;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign bus.imem_req    = (state_q == FETCH) && !reset;
    assign bus.imem_addr   = reset ? RESET_PC : pc_q;
    assign bus.instr_valid = (state_q == DELIVER) && !reset;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule
